pacman_map_writer: RTL
======================

Name: pacman_map_writer

Overview:
- Read-modify-write controller for the 64x128-bit Pacman map block memory. One map row per word, one bit per tile.
- Accepts single-tile update requests from game logic, e.g. clearing a pellet when Pacman eats it.
- Reads the row, modifies one bit, writes the row back through a read/write port of the map RAM, then reports the tile's previous value for scoring.
- Sits between the game-logic FSM and the write-capable port of the map memory; the display path keeps its read-only port.

Parameters:
- ROWS, 64: number of valid map rows; requests with row >= ROWS are rejected.
- RD_LAT, 1: block-memory read latency in cycles, from the address cycle to valid douta; legal values 1..3.

Ports:
- clka  in  1  system clock; all logic is rising-edge.
- rsta  in  1  synchronous, active-high reset.
- req_valid  in  1  update request valid.
- req_ready  out  1  controller idle and able to accept a request.
- req_row  in  6  map row (word address).
- req_col  in  7  tile column; column c maps to data bit 127-c (MSB is the leftmost tile).
- req_op  in  2  operation: 00 CLEAR, 01 SET, 10 TOGGLE, 11 QUERY (read only).
- done  out  1  one-cycle pulse when a request completes.
- was_set  out  1  tile bit value before modification; valid when done=1 and held until the next done.
- err  out  1  one-cycle pulse when a request is rejected (row >= ROWS).
- ena  out  1  memory enable.
- wea  out  1  memory write enable.
- addra  out  6  memory address.
- dina  out  128  memory write data.
- douta  in  128  memory read data.

Behaviour:
- Reset (rsta=1 at a clock edge):
  - State goes to IDLE; any in-flight request is abandoned with no write issued.
  - req_ready=1 from the first cycle after reset.
  - done=0, err=0, was_set=0, ena=0, wea=0, addra=0, dina=0.
- States: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - req_ready=1.
  - On req_valid=1, the request is accepted and row, col and op are captured.
  - If row >= ROWS: err pulses the next cycle and the FSM stays in IDLE.
  - Otherwise the FSM moves to RD.
- RD (one cycle):
  - ena=1, wea=0, addra=captured row.
  - The latency counter loads RD_LAT-1.
  - The FSM moves to WAIT, or, if RD_LAT=1, captures douta on the next edge and moves to WR.
- WAIT:
  - ena=0.
  - The counter decrements each cycle.
  - When it reaches 0, douta is captured into the row register on the following edge.
- WR, for CLEAR, SET or TOGGLE (one cycle):
  - ena=1, wea=1, addra=row.
  - dina equals the captured row with bit 127-col cleared, set, or inverted. All other 127 bits are unchanged.
  - The write is issued even if the bit already holds the target value.
- WR, for QUERY: ena=0, wea=0; no write is issued.
- FIN:
  - done=1 for one cycle.
  - was_set = original bit 127-col of the captured row.
  - Returns to IDLE.
- Latency: with the accept edge at cycle T, the read is issued at T+1, the write at T+1+RD_LAT, and done pulses at T+2+RD_LAT. With RD_LAT=1, done is at T+3.
- req_ready=0 in every state except IDLE. At most one request is outstanding, so there is no read/write hazard and no forwarding.
- After done, the next request can be accepted in the first IDLE cycle, i.e. the cycle after done.
- ena and wea are low in every state not listed above.
- addra and dina hold their last values when ena=0.
- req_row, req_col and req_op are ignored except when accepted in IDLE; changes mid-operation have no effect.
- done and err are never asserted in the same cycle.

Test Plan:
1. CLEAR pellet, RD_LAT=1: memory row 5 = all ones; request row=5, col=0, op=00 → write at T+2 to addr 5 with dina = 0x7FFF...FFFF (bit 127=0); done at T+3 with was_set=1.
2. SET on an empty tile: row 10 = 0; request col=127, op=01 → dina=0x0000...0001, was_set=0. Repeat the same request → write issued again, was_set=1.
3. TOGGLE then QUERY: row 0 = 0; TOGGLE col=64 → dina bit 63=1, was_set=0. QUERY col=64 → no wea pulse, done with was_set=1, memory unchanged.
4. Latency and back-pressure with RD_LAT=3: request row=63 → read at T+1, write at T+4, done at T+5. req_valid held high throughout → req_ready=0 from T+1 to T+5, and the second request is accepted at T+6.
5. Range check with ROWS=40: request row=40 → err pulse at T+1, ena never asserted, req_ready=1 at T+1. Request row=39 → completes normally.
6. Reset mid-operation: assert rsta during WAIT (RD_LAT=3) → no write issued, done stays 0, req_ready=1 the cycle after reset; a following request completes correctly.

Source files
------------

// File: rtl/pacman_map_writer_if.sv
// Request/response and map-RAM port bundle for the Pacman map writer.
// The slave side is the controller; the master side is game logic plus the RAM.
interface pacman_map_writer_if;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_row;
    logic [6:0]   req_col;
    logic [1:0]   req_op;
    logic         done;
    logic         was_set;
    logic         err;
    logic         ena;
    logic         wea;
    logic [5:0]   addra;
    logic [127:0] dina;
    logic [127:0] douta;

    modport master (
        output req_valid, req_row, req_col, req_op, douta,
        input  req_ready, done, was_set, err, ena, wea, addra, dina
    );

    modport slave (
        input  req_valid, req_row, req_col, req_op, douta,
        output req_ready, done, was_set, err, ena, wea, addra, dina
    );
endinterface

// File: rtl/pacman_map_writer.sv
// Read-modify-write controller that updates one tile bit of a 128-bit map row
// and reports the tile's previous value for scoring.
module pacman_map_writer #(
    parameter int ROWS   = 64,
    parameter int RD_LAT = 1
) (
    input logic                clka,
    input logic                rsta,
    pacman_map_writer_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WAIT, ST_WR, ST_FIN} state_t;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_QUERY  = 2'b11;

    state_t       state_q, state_d;
    logic [5:0]   row_q, row_d;
    logic [6:0]   col_q, col_d;
    logic [1:0]   op_q, op_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic         was_set_q, was_set_d;
    logic         err_q, err_d;
    logic [5:0]   addra_q, addra_d;
    logic [127:0] dina_q, dina_d;

    logic         ena, wea, ready, done, was_set;
    logic [5:0]   addra;
    logic [127:0] dina;
    logic [127:0] mask;
    logic [127:0] modified;

    // Column 0 is the leftmost tile and lives in bit 127, so the bit index is ~col.
    assign mask = 128'(1) << (~col_q);

    always_comb begin
        case (op_q)
            OP_CLEAR:  modified = bus.douta & ~mask;
            OP_SET:    modified = bus.douta | mask;
            OP_TOGGLE: modified = bus.douta ^ mask;
            default:   modified = bus.douta;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        was_set_d = was_set_q;
        err_d     = 1'b0;
        ena       = 1'b0;
        wea       = 1'b0;
        addra     = addra_q;
        dina      = dina_q;
        ready     = 1'b0;
        done      = 1'b0;
        was_set   = was_set_q;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    row_d = bus.req_row;
                    col_d = bus.req_col;
                    op_d  = bus.req_op;
                    if (32'(bus.req_row) >= ROWS) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                ena     = 1'b1;
                addra   = row_q;
                cnt_d   = 2'(RD_LAT - 1);
                state_d = (RD_LAT == 1) ? ST_WR : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                data_d = bus.douta;
                // A query still captures the row so FIN can report the bit.
                if (op_q != OP_QUERY) begin
                    ena   = 1'b1;
                    wea   = 1'b1;
                    addra = row_q;
                    dina  = modified;
                end
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done      = 1'b1;
                was_set   = data_q[~col_q];
                was_set_d = data_q[~col_q];
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        addra_d = addra;
        dina_d  = dina;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            was_set_q <= 1'b0;
            err_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            was_set_q <= was_set_d;
            err_q     <= err_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.done      = done;
    assign bus.was_set   = was_set;
    assign bus.err       = err_q;
    assign bus.ena       = ena;
    assign bus.wea       = wea;
    assign bus.addra     = addra;
    assign bus.dina      = dina;
endmodule
